// File: rtl/axi_w_order_arbiter.sv
// Shares one downstream AXI W channel between N_MASTERS sources. W bursts are
// forwarded whole, in the order the AW arbiter recorded its grants.
module axi_w_order_arbiter #(
    parameter int N_MASTERS   = 4,
    parameter int DATA_WIDTH  = 64,
    parameter int USER_WIDTH  = 6,
    parameter int ORDER_DEPTH = 4,
    parameter int STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int SRC_WIDTH   = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             aw_push_valid_i,
    input  logic [SRC_WIDTH-1:0]             aw_push_src_i,
    output logic                             aw_push_ready_o,
    input  logic [N_MASTERS-1:0]             slave_valid_i,
    input  logic [N_MASTERS*DATA_WIDTH-1:0]  slave_data_i,
    input  logic [N_MASTERS*STRB_WIDTH-1:0]  slave_strb_i,
    input  logic [N_MASTERS*USER_WIDTH-1:0]  slave_user_i,
    input  logic [N_MASTERS-1:0]             slave_last_i,
    output logic [N_MASTERS-1:0]             slave_ready_o,
    output logic                             master_valid_o,
    output logic [DATA_WIDTH-1:0]            master_data_o,
    output logic [STRB_WIDTH-1:0]            master_strb_o,
    output logic [USER_WIDTH-1:0]            master_user_o,
    output logic                             master_last_o,
    input  logic                             master_ready_i,
    output logic [$clog2(ORDER_DEPTH):0]     pending_o,
    output logic [7:0]                       beat_cnt_o,
    output logic                             src_err_o
);

    localparam int PTR_WIDTH = $clog2(ORDER_DEPTH);
    localparam int CNT_WIDTH = PTR_WIDTH + 1;
    localparam int SRC_EXT   = SRC_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(ORDER_DEPTH);
    localparam logic [SRC_EXT-1:0]   SRC_LIMIT  = SRC_EXT'(N_MASTERS);

    logic [SRC_WIDTH-1:0] order_mem [ORDER_DEPTH];
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [CNT_WIDTH-1:0] count;
    logic [SRC_WIDTH-1:0] head;
    logic                 empty;
    logic                 src_ok;
    logic                 push_hs;
    logic                 push;
    logic                 pop;
    logic                 beat_hs;
    logic                 head_valid;

    assign empty           = (count == '0);
    assign head            = order_mem[rd_ptr];
    // Ready depends on stored state only, so a same-cycle pop never frees a slot early.
    assign aw_push_ready_o = (count != FULL_COUNT);
    assign src_ok          = ({1'b0, aw_push_src_i} < SRC_LIMIT);
    assign push_hs         = aw_push_valid_i && aw_push_ready_o;
    assign push            = push_hs && src_ok;
    assign pending_o       = count;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        head_valid    = 1'b0;
        master_data_o = '0;
        master_strb_o = '0;
        master_user_o = '0;
        master_last_o = 1'b0;
        slave_ready_o = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (head == SRC_WIDTH'(i)) begin
                head_valid       = slave_valid_i[i];
                master_data_o    = slave_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                master_strb_o    = slave_strb_i[i*STRB_WIDTH +: STRB_WIDTH];
                master_user_o    = slave_user_i[i*USER_WIDTH +: USER_WIDTH];
                master_last_o    = slave_last_i[i];
                slave_ready_o[i] = !empty && master_ready_i;
            end
        end
    end

    assign master_valid_o = !empty && head_valid;
    assign beat_hs        = master_valid_o && master_ready_i;
    assign pop            = beat_hs && master_last_o;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            beat_cnt_o <= '0;
            src_err_o  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (beat_hs) begin
                if (master_last_o)             beat_cnt_o <= '0;
                else if (beat_cnt_o != 8'hFF)  beat_cnt_o <= beat_cnt_o + 8'd1;
            end
            src_err_o <= push_hs && !src_ok;
        end
    end

    // NOTE: the order storage is not reset; entries are only read while count says they are valid.
    always_ff @(posedge clk_i) begin
        if (push) order_mem[wr_ptr] <= aw_push_src_i;
    end

endmodule

// File: tb/tb_axi_w_order_arbiter.sv
// Directed bench for axi_w_order_arbiter: ordering, full/backpressure, wrap,
// mid-burst stall, out-of-range source and asynchronous reset mid-burst.
module tb_axi_w_order_arbiter;

    typedef struct {
        logic [63:0] data;
        int          src;
        int          beat;
        logic        last;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         aw_push_valid = 1'b0;
    logic [1:0]   aw_push_src = '0;
    logic         aw_push_ready;
    logic [3:0]   slave_valid;
    logic [255:0] slave_data;
    logic [31:0]  slave_strb;
    logic [23:0]  slave_user;
    logic [3:0]   slave_last;
    logic [3:0]   slave_ready;
    logic         master_valid;
    logic [63:0]  master_data;
    logic [7:0]   master_strb;
    logic [5:0]   master_user;
    logic         master_last;
    logic         master_ready = 1'b0;
    logic [2:0]   pending;
    logic [7:0]   beat_cnt;
    logic         src_err;

    // Second instance with three sources exercises the out-of-range index.
    logic         e_push_valid = 1'b0;
    logic [1:0]   e_push_src = '0;
    logic         e_push_ready;
    logic [2:0]   e_svalid = '0;
    logic [23:0]  e_sdata = '0;
    logic [2:0]   e_sstrb = '1;
    logic [5:0]   e_suser = '0;
    logic [2:0]   e_slast = '0;
    logic [2:0]   e_sready;
    logic         e_mvalid;
    logic [7:0]   e_mdata;
    logic [0:0]   e_mstrb;
    logic [1:0]   e_muser;
    logic         e_mlast;
    logic         e_mready = 1'b0;
    logic [2:0]   e_pending;
    logic [7:0]   e_beat;
    logic         e_err;

    int total = 0;
    int bad   = 0;

    int rem  [4];
    int blen [4];
    int beat [4];
    int bno  [4];
    beat_t exp_q [$];
    int    push_q [$];
    int    pend_q [$];

    axi_w_order_arbiter dut (
        .clk_i(clk), .rst_i(rst),
        .aw_push_valid_i(aw_push_valid), .aw_push_src_i(aw_push_src),
        .aw_push_ready_o(aw_push_ready),
        .slave_valid_i(slave_valid), .slave_data_i(slave_data),
        .slave_strb_i(slave_strb), .slave_user_i(slave_user),
        .slave_last_i(slave_last), .slave_ready_o(slave_ready),
        .master_valid_o(master_valid), .master_data_o(master_data),
        .master_strb_o(master_strb), .master_user_o(master_user),
        .master_last_o(master_last), .master_ready_i(master_ready),
        .pending_o(pending), .beat_cnt_o(beat_cnt), .src_err_o(src_err)
    );

    axi_w_order_arbiter #(.N_MASTERS(3), .DATA_WIDTH(8), .USER_WIDTH(2)) dut3 (
        .clk_i(clk), .rst_i(rst),
        .aw_push_valid_i(e_push_valid), .aw_push_src_i(e_push_src),
        .aw_push_ready_o(e_push_ready),
        .slave_valid_i(e_svalid), .slave_data_i(e_sdata),
        .slave_strb_i(e_sstrb), .slave_user_i(e_suser),
        .slave_last_i(e_slast), .slave_ready_o(e_sready),
        .master_valid_o(e_mvalid), .master_data_o(e_mdata),
        .master_strb_o(e_mstrb), .master_user_o(e_muser),
        .master_last_o(e_mlast), .master_ready_i(e_mready),
        .pending_o(e_pending), .beat_cnt_o(e_beat), .src_err_o(e_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Upstream source model: each source plays rem[s] bursts of blen[s] beats.
    task automatic drive_srcs();
        for (int s = 0; s < 4; s++) begin
            slave_valid[s]          = (rem[s] > 0);
            slave_data[s*64 +: 64]  = 64'(s*16 + beat[s] + bno[s]*256);
            slave_strb[s*8 +: 8]    = 8'(s + 1);
            slave_user[s*6 +: 6]    = 6'(s);
            slave_last[s]           = (beat[s] == blen[s] - 1);
        end
    endtask

    task automatic set_src(input int s, input int n, input int len);
        rem[s]  = n;
        blen[s] = len;
        beat[s] = 0;
        bno[s]  = 0;
        drive_srcs();
    endtask

    task automatic add_burst(input int s, input int n, input int len);
        for (int b = 0; b < len; b++)
            exp_q.push_back('{64'(s*16 + b + n*256), s, b, (b == len - 1)});
    endtask

    task automatic cycle();
        logic [3:0] acc;
        acc = slave_valid & slave_ready;
        @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) begin
            if (acc[s]) begin
                if (slave_last[s]) begin
                    beat[s] = 0;
                    bno[s]++;
                    rem[s]--;
                end else begin
                    beat[s]++;
                end
            end
        end
        drive_srcs();
    endtask

    // Pushes push_q one per accepted handshake and checks every forwarded beat.
    task automatic run_q(input int budget, output int first_hs, output int last_hs);
        beat_t e;
        int cyc = 0;
        first_hs = -1;
        last_hs  = -1;
        while ((exp_q.size() > 0 || push_q.size() > 0) && cyc < budget) begin
            aw_push_valid = (push_q.size() > 0);
            aw_push_src   = (push_q.size() > 0) ? 2'(push_q[0]) : 2'd0;
            #1;
            if (master_valid && master_ready) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("data", master_data, e.data);
                    chk("strb", 64'(master_strb), 64'(e.src + 1));
                    chk("user", 64'(master_user), 64'(e.src));
                    chk("last", 64'(master_last), 64'(e.last));
                    chk("beat_cnt", 64'(beat_cnt), 64'(e.beat));
                    if (master_last && pend_q.size() > 0)
                        chk("pending_at_last", 64'(pending), 64'(pend_q.pop_front()));
                end else begin
                    chk("extra_beat", 64'(master_valid), 64'(0));
                end
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
            end
            if (aw_push_valid && aw_push_ready) void'(push_q.pop_front());
            cycle();
            cyc++;
        end
        aw_push_valid = 1'b0;
        chk("drain_timeout", 64'(exp_q.size() + push_q.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_hs;
        int last_hs;

        // Reset held with every source valid.
        for (int s = 0; s < 4; s++) set_src(s, 1, 1);
        master_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #2;
            chk("rst_mvalid", 64'(master_valid), 64'(0));
            chk("rst_sready", 64'(slave_ready), 64'(0));
            chk("rst_push_rdy", 64'(aw_push_ready), 64'(1));
            chk("rst_pending", 64'(pending), 64'(0));
        end
        rst = 1'b0;
        for (int s = 0; s < 4; s++) set_src(s, 0, 1);

        // Ordering: grants 2,0,3, three beats each.
        set_src(2, 1, 3);
        set_src(0, 1, 3);
        set_src(3, 1, 3);
        push_q = '{2, 0, 3};
        add_burst(2, 0, 3);
        add_burst(0, 0, 3);
        add_burst(3, 0, 3);
        pend_q = '{3, 2, 1};
        run_q(40, first_hs, last_hs);
        #1;
        chk("order_pending_end", 64'(pending), 64'(0));
        chk("order_first_latency", 64'(first_hs), 64'(1));

        // Full and backpressure.
        master_ready = 1'b0;
        set_src(0, 2, 1);
        set_src(1, 1, 1);
        set_src(2, 1, 1);
        set_src(3, 1, 1);
        for (int k = 0; k < 4; k++) begin
            aw_push_valid = 1'b1;
            aw_push_src   = 2'(k);
            #1;
            chk("fill_push_rdy", 64'(aw_push_ready), 64'(1));
            cycle();
        end
        aw_push_src = 2'd0;
        repeat (2) begin
            #1;
            chk("full_pending", 64'(pending), 64'(4));
            chk("full_push_rdy", 64'(aw_push_ready), 64'(0));
            cycle();
        end
        master_ready = 1'b1;
        #1;
        chk("pop_cycle_push_rdy", 64'(aw_push_ready), 64'(0));
        chk("pop_cycle_last", 64'(master_last), 64'(1));
        chk("pop_cycle_data", master_data, 64'h00);
        cycle();
        master_ready = 1'b0;
        #1;
        chk("after_pop_pending", 64'(pending), 64'(3));
        chk("after_pop_push_rdy", 64'(aw_push_ready), 64'(1));
        cycle();
        aw_push_valid = 1'b0;
        #1;
        chk("refill_pending", 64'(pending), 64'(4));
        chk("refill_push_rdy", 64'(aw_push_ready), 64'(0));
        master_ready = 1'b1;
        add_burst(1, 0, 1);
        add_burst(2, 0, 1);
        add_burst(3, 0, 1);
        add_burst(0, 1, 1);
        run_q(20, first_hs, last_hs);
        #1;
        chk("full_drain_pending", 64'(pending), 64'(0));

        // Wrap: ten single-beat bursts from source 1, one push per cycle.
        set_src(1, 10, 1);
        for (int n = 0; n < 10; n++) begin
            push_q.push_back(1);
            add_burst(1, n, 1);
        end
        run_q(30, first_hs, last_hs);
        chk("wrap_first_beat", 64'(first_hs), 64'(1));
        chk("wrap_last_beat", 64'(last_hs), 64'(10));
        #1;
        chk("wrap_pending_end", 64'(pending), 64'(0));

        // Stall mid-burst with a valid non-head source.
        set_src(0, 1, 4);
        set_src(3, 1, 1);
        master_ready  = 1'b1;
        aw_push_valid = 1'b1;
        aw_push_src   = 2'd0;
        #1;
        chk("stall_empty_mvalid", 64'(master_valid), 64'(0));
        cycle();
        aw_push_valid = 1'b0;
        #1;
        chk("stall_beat0", master_data, 64'h00);
        cycle();
        master_ready = 1'b0;
        repeat (2) begin
            #1;
            chk("stall_beat_cnt", 64'(beat_cnt), 64'(1));
            chk("stall_data", master_data, 64'h01);
            chk("stall_mvalid", 64'(master_valid), 64'(1));
            chk("stall_sready", 64'(slave_ready), 64'(0));
            cycle();
        end
        master_ready = 1'b1;
        for (int b = 1; b < 4; b++) begin
            #1;
            chk("resume_data", master_data, 64'(b));
            chk("resume_beat_cnt", 64'(beat_cnt), 64'(b));
            cycle();
        end
        #1;
        chk("stall_end_beat_cnt", 64'(beat_cnt), 64'(0));
        chk("stall_end_sready", 64'(slave_ready), 64'(0));
        chk("stall_end_mvalid", 64'(master_valid), 64'(0));
        set_src(3, 0, 1);

        // Out-of-range source on the three-source instance.
        e_push_valid = 1'b1;
        e_push_src   = 2'd1;
        cycle();
        e_push_src = 2'd3;
        #1;
        chk("err_push_rdy", 64'(e_push_ready), 64'(1));
        chk("err_before", 64'(e_err), 64'(0));
        cycle();
        e_push_valid = 1'b0;
        #1;
        chk("err_pulse", 64'(e_err), 64'(1));
        chk("err_pending", 64'(e_pending), 64'(1));
        cycle();
        #1;
        chk("err_clear", 64'(e_err), 64'(0));
        chk("err_pending_hold", 64'(e_pending), 64'(1));

        // Burst on source 1, then asynchronous reset after two beats.
        e_mready = 1'b1;
        e_svalid = 3'b010;
        e_sdata  = {8'h00, 8'hA0, 8'h00};
        #1;
        chk("e_beat0_data", 64'(e_mdata), 64'hA0);
        chk("e_beat0_valid", 64'(e_mvalid), 64'(1));
        cycle();
        e_sdata = {8'h00, 8'hA1, 8'h00};
        #1;
        chk("e_beat1_data", 64'(e_mdata), 64'hA1);
        cycle();
        e_sdata = {8'h00, 8'hA2, 8'h00};
        #1;
        chk("e_beat_cnt_2", 64'(e_beat), 64'(2));
        rst = 1'b1;
        #1;
        chk("arst_pending", 64'(e_pending), 64'(0));
        chk("arst_beat_cnt", 64'(e_beat), 64'(0));
        chk("arst_mvalid", 64'(e_mvalid), 64'(0));
        cycle();
        rst = 1'b0;
        #1;
        chk("release_mvalid", 64'(e_mvalid), 64'(0));
        cycle();
        #1;
        chk("post_release_mvalid", 64'(e_mvalid), 64'(0));
        chk("post_release_sready", 64'(e_sready), 64'(0));
        chk("post_release_pending", 64'(e_pending), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
